// File: rtl/cobs_pkg.sv
// Shared constants, state encodings and helpers for the COBS transmit framer.
package cobs_pkg;

    localparam logic [7:0] COBS_DELIM   = 8'h00;
    localparam int         COBS_MAX_RUN = 254;

    typedef enum logic [2:0] {
        ST_FILL  = 3'd0,
        ST_CODE  = 3'd1,
        ST_DATA  = 3'd2,
        ST_DELIM = 3'd3,
        ST_GAP   = 3'd4
    } cobs_state_e;

    // A block holding 'run' non-zero bytes is announced by code byte run+1.
    function automatic logic [7:0] cobs_code(input logic [7:0] run);
        return run + 8'd1;
    endfunction

endpackage

// File: rtl/cobs_block_buf.sv
// Holding buffer for the non-zero bytes of one COBS block.
// One write port and one registered read port, so it maps onto block RAM.
module cobs_block_buf #(
    parameter int DEPTH = 254
) (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [DEPTH];

    // Write when asked; read every cycle with one cycle of latency.
    // NOTE: the array and its read register have no reset -- a reset port would
    // stop the tools from mapping it onto RAM, and every location is written
    // before it is read anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/cobs_encoder.sv
// COBS transmit framer: collects payload bytes into blocks, then hands the
// code byte, the block data and finally the 0x00 delimiter to the UART one
// byte at a time using the o_flag / busy handshake.
module cobs_encoder
    import cobs_pkg::*;
#(
    parameter int MAX_RUN    = COBS_MAX_RUN,  // 1..254
    parameter int GAP_CYCLES = 1              // 1..256, idle cycles after each pulse
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    input  logic       busy,
    output logic       o_flag,
    output logic [7:0] o_data,
    output logic       frame_done
);

    cobs_state_e state_q, state_d;
    cobs_state_e ret_q, ret_d;      // state resumed once the GAP expires
    cobs_state_e post_ret;          // where to go once the current block is out
    logic [7:0]  cnt_q, cnt_d;      // non-zero bytes held for the current block
    logic [7:0]  rd_ptr_q, rd_ptr_d;
    logic        tail_q, tail_d;    // frame ended on a zero: an empty block follows
    logic        frame_end_q, frame_end_d;
    logic [7:0]  gap_q, gap_d;
    logic        o_flag_q, o_flag_d;
    logic [7:0]  o_data_q, o_data_d;
    logic        frame_done_q, frame_done_d;
    logic        buf_we;
    logic [7:0]  buf_rdata;
    logic        accept;

    // The read port always addresses rd_ptr_q, so the next data byte is
    // already waiting in buf_rdata by the time the GAP ends.
    cobs_block_buf #(.DEPTH(MAX_RUN)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (cnt_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (buf_rdata)
    );

    assign in_ready = (state_q == ST_FILL) && (cnt_q < 8'(MAX_RUN)) && !rst;
    assign accept   = in_valid && in_ready;

    // Outputs are forced quiet while reset is held, even in its first cycle.
    assign o_flag     = o_flag_q && !rst;
    assign o_data     = rst ? COBS_DELIM : o_data_q;
    assign frame_done = frame_done_q && !rst;

    // Decision taken after the last byte of a block: pending empty block
    // first, then the delimiter if the frame has ended, else more payload.
    always_comb begin
        post_ret = ST_FILL;
        if (tail_q) begin
            post_ret = ST_CODE;
        end else if (frame_end_q) begin
            post_ret = ST_DELIM;
        end
    end

    // Next-state and output logic of the framing FSM.
    // NOTE: every variable assigned here gets a default at the top of the
    // block, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        cnt_d        = cnt_q;
        rd_ptr_d     = rd_ptr_q;
        tail_d       = tail_q;
        frame_end_d  = frame_end_q;
        gap_d        = gap_q;
        o_flag_d     = 1'b0;
        o_data_d     = o_data_q;
        frame_done_d = 1'b0;
        buf_we       = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    if (in_data != COBS_DELIM) begin
                        buf_we = 1'b1;
                        cnt_d  = cnt_q + 8'd1;
                        if (cnt_d == 8'(MAX_RUN)) begin
                            // Full block: the frame may or may not end here.
                            state_d     = ST_CODE;
                            frame_end_d = in_last;
                        end else if (in_last) begin
                            state_d     = ST_CODE;
                            frame_end_d = 1'b1;
                        end
                    end else begin
                        // A zero is never stored; it only closes the block.
                        state_d     = ST_CODE;
                        frame_end_d = in_last;
                        tail_d      = in_last;
                    end
                end
            end

            ST_CODE: begin
                if (!busy) begin
                    o_flag_d = 1'b1;
                    o_data_d = cobs_code(cnt_q);
                    state_d  = ST_GAP;
                    if (cnt_q != 8'd0) begin
                        ret_d = ST_DATA;
                    end else begin
                        ret_d    = post_ret;
                        cnt_d    = 8'd0;
                        rd_ptr_d = 8'd0;
                        tail_d   = 1'b0;
                    end
                end
            end

            ST_DATA: begin
                if (!busy) begin
                    o_flag_d = 1'b1;
                    o_data_d = buf_rdata;
                    state_d  = ST_GAP;
                    rd_ptr_d = rd_ptr_q + 8'd1;
                    if (rd_ptr_q == cnt_q - 8'd1) begin
                        ret_d    = post_ret;
                        cnt_d    = 8'd0;
                        rd_ptr_d = 8'd0;
                        tail_d   = 1'b0;
                    end else begin
                        ret_d = ST_DATA;
                    end
                end
            end

            ST_DELIM: begin
                if (!busy) begin
                    o_flag_d     = 1'b1;
                    o_data_d     = COBS_DELIM;
                    frame_done_d = 1'b1;
                    frame_end_d  = 1'b0;
                    state_d      = ST_GAP;
                    ret_d        = ST_FILL;
                end
            end

            ST_GAP: begin
                if (gap_q == 8'(GAP_CYCLES - 1)) begin
                    gap_d   = 8'd0;
                    state_d = ret_q;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FILL;
            ret_q        <= ST_FILL;
            cnt_q        <= 8'd0;
            rd_ptr_q     <= 8'd0;
            tail_q       <= 1'b0;
            frame_end_q  <= 1'b0;
            gap_q        <= 8'd0;
            o_flag_q     <= 1'b0;
            o_data_q     <= COBS_DELIM;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            cnt_q        <= cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            tail_q       <= tail_d;
            frame_end_q  <= frame_end_d;
            gap_q        <= gap_d;
            o_flag_q     <= o_flag_d;
            o_data_q     <= o_data_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
